// File: rtl/bt_command_hold.sv
// Bluetooth/UART joint command holder: decodes single-byte move/stop commands
// into one-hot joint drive outputs that expire after TIMEOUT_CYCLES clocks.
module bt_command_hold #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxData,
  input  logic       rxDone,
  output logic [3:0] isClockWise,
  output logic [3:0] isCounterClock,
  output logic       busy,
  output logic [7:0] lastCmd,
  output logic [7:0] badCount
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]    state_q,       state_d;
  logic [3:0]    cw_q,          cw_d;
  logic [3:0]    ccw_q,         ccw_d;
  logic [TW-1:0] timer_q,       timer_d;
  logic [7:0]    last_q,        last_d;
  logic [7:0]    bad_q,         bad_d;
  logic          rxdone_prev_q, rxdone_prev_d;

  logic       accept;
  logic [3:0] cw_dec;
  logic [3:0] ccw_dec;
  logic       is_move;
  logic       is_stop;
  logic       is_bad;

  // Odd codes 1,3,5,7 select clockwise joints 0..3; even codes 2,4,6,8 counter-clockwise.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign cw_dec[gi]  = (rxData == 8'(2 * gi + 1));
      assign ccw_dec[gi] = (rxData == 8'(2 * gi + 2));
    end
  endgenerate

  assign accept  = rxDone & ~rxdone_prev_q;
  assign is_move = (|cw_dec) | (|ccw_dec);
  assign is_stop = (rxData == 8'h00);
  assign is_bad  = ~is_move & ~is_stop;

  always_comb begin
    state_d       = state_q;
    cw_d          = cw_q;
    ccw_d         = ccw_q;
    timer_d       = timer_q;
    last_d        = last_q;
    bad_d         = bad_q;
    rxdone_prev_d = rxDone;

    if (accept && is_move) begin
      state_d = ST_DRIVE;
      cw_d    = cw_dec;
      ccw_d   = ccw_dec;
      timer_d = '0;
      last_d  = rxData;
    end else if (accept && is_stop) begin
      state_d = ST_IDLE;
      cw_d    = '0;
      ccw_d   = '0;
      timer_d = '0;
      last_d  = 8'h00;
    end else begin
      // Invalid bytes only touch the error counter; a running move keeps its schedule.
      if (accept && is_bad && (bad_q != 8'hFF)) begin
        bad_d = bad_q + 8'd1;
      end
      if (state_q == ST_DRIVE) begin
        if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
          cw_d    = '0;
          ccw_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cw_q          <= '0;
      ccw_q         <= '0;
      timer_q       <= '0;
      last_q        <= 8'h00;
      bad_q         <= 8'h00;
      // Held high so an rxDone already asserted at release is not taken as a new byte.
      rxdone_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cw_q          <= cw_d;
      ccw_q         <= ccw_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      bad_q         <= bad_d;
      rxdone_prev_q <= rxdone_prev_d;
    end
  end

  assign isClockWise    = cw_q;
  assign isCounterClock = ccw_q;
  assign busy           = (state_q == ST_DRIVE);
  assign lastCmd        = last_q;
  assign badCount       = bad_q;

endmodule

// File: tb/tb_bt_command_hold.sv
// Directed bench for bt_command_hold with a 16-cycle move timeout.
module tb_bt_command_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDone;
  logic [3:0] isClockWise;
  logic [3:0] isCounterClock;
  logic       busy;
  logic [7:0] lastCmd;
  logic [7:0] badCount;

  int checks   = 0;
  int failures = 0;

  bt_command_hold #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .rxData         (rxData),
    .rxDone         (rxDone),
    .isClockWise    (isClockWise),
    .isCounterClock (isCounterClock),
    .busy           (busy),
    .lastCmd        (lastCmd),
    .badCount       (badCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] cw, input logic [3:0] ccw);
    chk({tag, ".cw"},   32'(isClockWise),    32'(cw));
    chk({tag, ".ccw"},  32'(isCounterClock), 32'(ccw));
    chk({tag, ".busy"}, 32'(busy),           32'((cw | ccw) != 4'b0000));
  endtask

  // One accepting edge, rxDone dropped right after it.
  task automatic send(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
  endtask

  // n idle edges with rxData wandering over move/stop codes while rxDone stays low.
  task automatic drive_check(input string tag, input int n, input logic [3:0] cw, input logic [3:0] ccw);
    for (int i = 0; i < n; i++) begin
      rxData = 8'(i % 9);
      tick();
      chk_out(tag, cw, ccw);
    end
  endtask

  initial begin
    rst    = 1'b1;
    rxDone = 1'b0;
    rxData = 8'h00;
    tick();
    tick();
    chk_out("reset", 4'b0000, 4'b0000);
    chk("reset.last", 32'(lastCmd), 32'h00);
    chk("reset.bad",  32'(badCount), 32'h00);
    rst = 1'b0;
    tick();
    chk_out("post_reset", 4'b0000, 4'b0000);

    // Single move and its timeout exactly 16 edges after acceptance.
    send(8'h03);
    chk_out("m03", 4'b0010, 4'b0000);
    chk("m03.last", 32'(lastCmd), 32'h03);
    drive_check("m03_hold", 15, 4'b0010, 4'b0000);
    drive_check("m03_tmo", 1, 4'b0000, 4'b0000);

    // Replacement move five edges later.
    send(8'h03);
    drive_check("r03_hold", 4, 4'b0010, 4'b0000);
    send(8'h06);
    chk_out("r06", 4'b0000, 4'b0100);
    chk("r06.last", 32'(lastCmd), 32'h06);
    drive_check("r06_hold", 15, 4'b0000, 4'b0100);
    drive_check("r06_tmo", 1, 4'b0000, 4'b0000);

    // Refresh on the last high edge.
    send(8'h05);
    drive_check("f05_a", 14, 4'b0100, 4'b0000);
    send(8'h05);
    chk_out("f05_re", 4'b0100, 4'b0000);
    drive_check("f05_b", 15, 4'b0100, 4'b0000);
    drive_check("f05_tmo", 1, 4'b0000, 4'b0000);

    // Refresh landing on the timeout edge itself: acceptance wins.
    send(8'h05);
    drive_check("c05_a", 15, 4'b0100, 4'b0000);
    send(8'h05);
    chk_out("c05_re", 4'b0100, 4'b0000);
    drive_check("c05_b", 15, 4'b0100, 4'b0000);
    drive_check("c05_tmo", 1, 4'b0000, 4'b0000);

    // Stop on the last high edge.
    send(8'h05);
    drive_check("s05_a", 14, 4'b0100, 4'b0000);
    send(8'h00);
    chk_out("stop", 4'b0000, 4'b0000);
    chk("stop.last", 32'(lastCmd), 32'h00);
    drive_check("stop_idle", 3, 4'b0000, 4'b0000);

    // Invalid bytes during a move leave the move and its schedule alone.
    send(8'h01);
    chk_out("b01", 4'b0001, 4'b0000);
    chk("b01.bad", 32'(badCount), 32'd0);
    drive_check("b01_a", 2, 4'b0001, 4'b0000);
    send(8'h41);
    chk_out("bad41", 4'b0001, 4'b0000);
    chk("bad41.cnt",  32'(badCount), 32'd1);
    chk("bad41.last", 32'(lastCmd),  32'h01);
    drive_check("b01_b", 2, 4'b0001, 4'b0000);
    send(8'hFF);
    chk_out("badFF", 4'b0001, 4'b0000);
    chk("badFF.cnt",  32'(badCount), 32'd2);
    chk("badFF.last", 32'(lastCmd),  32'h01);
    drive_check("b01_c", 9, 4'b0001, 4'b0000);
    drive_check("b01_tmo", 1, 4'b0000, 4'b0000);

    // 300 invalid bytes total: count saturates at 255.
    for (int i = 0; i < 253; i++) begin
      send(8'h09 + 8'(i % 200));
      tick();
    end
    chk("sat255", 32'(badCount), 32'd255);
    for (int i = 0; i < 47; i++) begin
      send(8'hE0 + 8'(i % 16));
      tick();
    end
    chk("sat_hold", 32'(badCount), 32'd255);
    chk("sat.last", 32'(lastCmd), 32'h01);
    chk_out("sat_idle", 4'b0000, 4'b0000);

    // rxDone held high for 10 edges accepts once: timeout stays 16 edges after the first.
    rxData = 8'h01;
    rxDone = 1'b1;
    tick();
    chk_out("lvl01", 4'b0001, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out("lvl01_hi", 4'b0001, 4'b0000);
    end
    rxDone = 1'b0;
    drive_check("lvl01_lo", 6, 4'b0001, 4'b0000);
    drive_check("lvl01_tmo", 1, 4'b0000, 4'b0000);

    // Reset mid-move on an accepting edge, with rxDone held through release.
    send(8'h03);
    drive_check("pre_rst", 2, 4'b0010, 4'b0000);
    rst    = 1'b1;
    rxData = 8'h05;
    rxDone = 1'b1;
    tick();
    chk_out("rst_hit", 4'b0000, 4'b0000);
    chk("rst_hit.last", 32'(lastCmd),  32'h00);
    chk("rst_hit.bad",  32'(badCount), 32'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rel_high", 4'b0000, 4'b0000);
    end
    rxDone = 1'b0;
    tick();
    chk_out("rel_low", 4'b0000, 4'b0000);
    rxData = 8'h03;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    chk_out("rel_rise", 4'b0010, 4'b0000);
    chk("rel_rise.last", 32'(lastCmd), 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bt_command_hold.md
BT_COMMAND_HOLD -- requirements
Module: bt_command_hold

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, which sets the clocks a move command stays asserted without a refresh; legal minimum is 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port rxData, input, 8 bits: received byte from the UART receiver.
REQ-005 The block SHALL have port rxDone, input, 1 bit: UART byte-complete flag, level or pulse, any width.
REQ-006 The block SHALL have port isClockWise, output, 4 bits: bit j drives joint j clockwise.
REQ-007 The block SHALL have port isCounterClock, output, 4 bits: bit j drives joint j counter-clockwise.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in DRIVE.
REQ-009 The block SHALL have port lastCmd, output, 8 bits: last accepted valid byte, stop included.
REQ-010 The block SHALL have port badCount, output, 8 bits: saturating count of invalid bytes.

Function
REQ-011 The block SHALL register rxDone into rxDonePrev every cycle; a byte is accepted on a clock edge where rxDone=1 and rxDonePrev=0, so each rxDone rising edge accepts exactly once.
REQ-012 Byte decode SHALL be: 0x01/0x03/0x05/0x07 = clockwise joint 0/1/2/3; 0x02/0x04/0x06/0x08 = counter-clockwise joint 0/1/2/3; 0x00 = stop; any other value is invalid.
REQ-013 The FSM SHALL have two states: IDLE, with all isClockWise/isCounterClock bits 0, and DRIVE, with exactly one bit of the combined 8 output bits at 1.
REQ-014 On acceptance of a move byte, in either state, the block SHALL enter DRIVE, drive only the decoded bit, clear all other bits, load timer to 0, and set lastCmd to the byte.
REQ-015 Outputs SHALL be registered, with latency 1 clock: new output values are visible after the same edge that accepts the byte.
REQ-016 On acceptance of 0x00 the block SHALL go to IDLE, clear all outputs, clear timer, and set lastCmd to 0x00.
REQ-017 In DRIVE with no acceptance, timer SHALL increment by 1 per clock; at the edge where timer equals TIMEOUT_CYCLES-1, the block SHALL go to IDLE and clear outputs, so a move lasts exactly TIMEOUT_CYCLES clocks after its accepting edge.
REQ-018 Timer width SHALL be ceil(log2(TIMEOUT_CYCLES)) bits and SHALL never wrap.
REQ-019 If an acceptance and a timeout fall on the same edge, the acceptance SHALL win: a move byte reloads the timer and stays in DRIVE, and a stop byte goes to IDLE.
REQ-020 An accepted invalid byte SHALL increment badCount, saturating at 255, and SHALL NOT change state, outputs, timer, or lastCmd.
REQ-021 Re-accepting the same move byte SHALL keep the same output bit high with no glitch and reload the timer.
REQ-022 rxData SHALL be sampled only on an accepting edge; rxData changes at other times SHALL have no effect.
REQ-023 busy SHALL equal 1 exactly when the state is DRIVE.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set state IDLE, isClockWise=0, isCounterClock=0, busy=0, timer=0, lastCmd=0x00, badCount=0, and rxDonePrev=1.
REQ-025 Because rxDonePrev resets to 1, an rxDone held high through reset release SHALL NOT cause an acceptance; acceptance requires a fresh low-to-high transition.
REQ-026 rst SHALL have priority over every other event, including asserting rst mid-DRIVE or on an accepting edge; outputs SHALL be 0 on the following cycle.

Verification (bench uses TIMEOUT_CYCLES=16)
REQ-027 The bench SHALL apply rxData=0x03 with a 1-cycle rxDone pulse and check that on the next cycle isClockWise=0010 and busy=1, and that 16 cycles after the accepting edge isClockWise=0000 and busy=0.
REQ-028 The bench SHALL send 0x03, then 0x06 5 cycles later, and check isClockWise=0000, isCounterClock=0100, lastCmd=0x06, and timeout 16 cycles after the 0x06 edge.
REQ-029 The bench SHALL send 0x05 and then, on cycle 15 exactly, send 0x05 again, and check the bit stays high with no gap and drops 16 cycles after the second accept; repeated with 0x00 at cycle 15, outputs SHALL be 0 with no gap.
REQ-030 The bench SHALL send 0x41 and 0xFF while in DRIVE and check outputs and timer are undisturbed and badCount=2; it SHALL then send 300 invalid bytes and check badCount=255.
REQ-031 The bench SHALL hold rxDone=1 for 10 cycles with 0x01 and check exactly one acceptance; it SHALL then assert rst with rxDone still high, release it, and check busy=0 and no acceptance until rxDone falls and rises again.
